// File: rtl/matmul_pkg.sv
// matmul_pkg: definitions shared by the matrix-multiply blocks (input memories, sequencer, MAC).
//   - state_t plus the St* constants: sequencer FSM encoding (IDLE, RUN, DRAIN, DONE).
//   - clog2_min1: $clog2 that never yields a zero-width field.
//   - k_bits / a_addr_bits / b_addr_bits: widths of K and of the A/B read addresses.
package matmul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StDone  = 2'd3;

    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // K must be able to hold MAXK itself, not just MAXK-1.
    function automatic int unsigned k_bits(input int unsigned maxk);
        return clog2_min1(maxk + 1);
    endfunction

    function automatic int unsigned a_addr_bits(input int unsigned m, input int unsigned maxk);
        return clog2_min1(m * maxk);
    endfunction

    function automatic int unsigned b_addr_bits(input int unsigned maxk, input int unsigned n);
        return clog2_min1(maxk * n);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: handshake and memory-address bundle between the matmul sequencer and its
// neighbours (input memories, MAC/output stage, load controller).
//   matrices_loaded  load side -> sequencer: A/B resident and K stable (level)
//   K                load side -> sequencer: shared dimension
//   out_ready        output stage -> sequencer: room for one more C element
//   A_read_addr      sequencer -> A memory
//   B_read_addr      sequencer -> B memory
//   mac_en/init/last sequencer -> MAC: strobes aligned with returned read data
//   busy             sequencer: computing (RUN or DRAIN)
//   compute_finished sequencer -> load side: level, held until matrices_loaded drops
//   cycle_count      sequencer: compute-phase cycle counter, present only when
//                    MATMUL_SEQ_CYCLE_COUNT_EN is defined
// Modport master is the sequencer side; slave is the environment side.
interface matmul_sequencer_if
    import matmul_pkg::*;
#(
    parameter int unsigned M    = 7,
    parameter int unsigned N    = 9,
    parameter int unsigned MAXK = 8
) ();

    localparam int unsigned K_BITS      = k_bits(MAXK);
    localparam int unsigned A_ADDR_BITS = a_addr_bits(M, MAXK);
    localparam int unsigned B_ADDR_BITS = b_addr_bits(MAXK, N);

    logic                   matrices_loaded;
    logic [K_BITS-1:0]      K;
    logic                   out_ready;
    logic [A_ADDR_BITS-1:0] A_read_addr;
    logic [B_ADDR_BITS-1:0] B_read_addr;
    logic                   mac_en;
    logic                   mac_init;
    logic                   mac_last;
    logic                   busy;
    logic                   compute_finished;
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    logic [31:0]            cycle_count;
`endif

    modport master (
        input  matrices_loaded,
        input  K,
        input  out_ready,
        output A_read_addr,
        output B_read_addr,
        output mac_en,
        output mac_init,
        output mac_last,
        output busy,
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        output cycle_count,
`endif
        output compute_finished
    );

    modport slave (
        output matrices_loaded,
        output K,
        output out_ready,
        input  A_read_addr,
        input  B_read_addr,
        input  mac_en,
        input  mac_init,
        input  mac_last,
        input  busy,
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        input  compute_finished
    );

endinterface

// File: rtl/matmul_sequencer_wrap_counter.sv
// wrap_counter: loadable-limit up-counter used for the k, n and m loop indices.
//   clk    clock
//   reset  synchronous active-high reset
//   clear  synchronous clear (new compute run)
//   en     advance by one this cycle
//   limit  runtime terminal value; the counter wraps to 0 after reaching it
//   count  current value
//   wrap   combinational: en is high and count equals limit (feeds the next counter's en)
module wrap_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap  = en && (count_q == limit);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: walks every C[m][n] in row-major order, issuing one A/B read-address pair
// per cycle, and raises MAC strobes one cycle later to line up with the registered read data.
//   clk    sole clock
//   reset  synchronous active-high reset; every output reads 0 the cycle after it is sampled
//   bus    matmul_sequencer_if.master: matrices_loaded, K, out_ready in; A_read_addr,
//          B_read_addr, mac_en, mac_init, mac_last, busy, compute_finished out
// Optional feature: define MATMUL_SEQ_CYCLE_COUNT_EN to add the 32-bit cycle_count output,
// counting every RUN/DRAIN cycle (stalls included) of the latest run.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned M    = 7,
    parameter int unsigned N    = 9,
    parameter int unsigned MAXK = 8
) (
    input  logic                clk,
    input  logic                reset,
    matmul_sequencer_if.master  bus
);

    localparam int unsigned K_BITS      = k_bits(MAXK);
    localparam int unsigned A_ADDR_BITS = a_addr_bits(M, MAXK);
    localparam int unsigned B_ADDR_BITS = b_addr_bits(MAXK, N);
    localparam int unsigned N_BITS      = clog2_min1(N);
    localparam int unsigned M_BITS      = clog2_min1(M);

    state_t                 state_q, state_d;
    logic [K_BITS-1:0]      k_max_q;
    logic [A_ADDR_BITS-1:0] a_base_q;
    logic [B_ADDR_BITS-1:0] b_addr_q;
    logic                   mac_en_q, mac_init_q, mac_last_q;

    logic                   start;
    logic                   issue;
    logic                   in_compute;
    logic [K_BITS-1:0]      k_cnt;
    logic [N_BITS-1:0]      n_cnt;
    logic [M_BITS-1:0]      m_cnt;
    logic                   k_wrap, n_wrap, m_wrap;
    logic                   last_row;

    assign start      = (state_q == StIdle) && bus.matrices_loaded;
    assign in_compute = (state_q == StRun) || (state_q == StDrain);
    // out_ready only gates the first product of an element; a started element always finishes.
    assign issue      = (state_q == StRun) && (k_max_q != '0) && ((k_cnt != '0) || bus.out_ready);
    assign last_row   = (m_cnt == M_BITS'(M - 1));

    wrap_counter #(.WIDTH(K_BITS)) u_k_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (issue),
        .limit (k_max_q - K_BITS'(1)),
        .count (k_cnt),
        .wrap  (k_wrap)
    );

    wrap_counter #(.WIDTH(N_BITS)) u_n_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (k_wrap),
        .limit (N_BITS'(N - 1)),
        .count (n_cnt),
        .wrap  (n_wrap)
    );

    wrap_counter #(.WIDTH(M_BITS)) u_m_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (n_wrap),
        .limit (M_BITS'(M - 1)),
        .count (m_cnt),
        .wrap  (m_wrap)
    );

    // A K of 0 still spends one RUN cycle so the freshly latched k_max_q can be inspected.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.matrices_loaded) state_d = StRun;
            StRun: begin
                if (k_max_q == '0) begin
                    state_d = StDone;
                end else if (m_wrap) begin
                    state_d = StDrain;
                end
            end
            StDrain: state_d = StDone;
            StDone:  if (!bus.matrices_loaded) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            k_max_q    <= '0;
            a_base_q   <= '0;
            b_addr_q   <= '0;
            mac_en_q   <= 1'b0;
            mac_init_q <= 1'b0;
            mac_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mac_en_q   <= issue;
            mac_init_q <= issue && (k_cnt == '0);
            mac_last_q <= issue && k_wrap;
            if (start) begin
                k_max_q  <= bus.K;
                a_base_q <= '0;
                b_addr_q <= '0;
            end else if (issue) begin
                if (k_wrap) begin
                    // B restarts at the top of the next column; A moves to the next row base.
                    b_addr_q <= n_wrap ? '0 : B_ADDR_BITS'(n_cnt) + B_ADDR_BITS'(1);
                    if (n_wrap) begin
                        a_base_q <= last_row ? '0 : a_base_q + A_ADDR_BITS'(k_max_q);
                    end
                end else begin
                    b_addr_q <= b_addr_q + B_ADDR_BITS'(N);
                end
            end
        end
    end

    assign bus.A_read_addr      = a_base_q + A_ADDR_BITS'(k_cnt);
    assign bus.B_read_addr      = b_addr_q;
    assign bus.mac_en           = mac_en_q;
    assign bus.mac_init         = mac_init_q;
    assign bus.mac_last         = mac_last_q;
    assign bus.busy             = in_compute;
    assign bus.compute_finished = (state_q == StDone);

`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cycle_count_q <= '0;
        end else if (in_compute) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: a 2x2 instance and a default 7x9 instance share one clock.
// A loop-nest model queues the expected (A, B, init, last) of every product; one compare
// process pairs each mac_en with the address presented the cycle before and checks it.
// Directed sequences add literal expectations for issue order, latency, stalls and resets.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    typedef struct {
        int a;
        int b;
        int init;
        int last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_s, rst_d;
    int   total, bad;

    exp_t q0[$];
    exp_t q1[$];
    int   log_a0[$], log_b0[$], log_i0[$], log_l0[$];
    int   en_cnt1, last_a1, last_b1;
    int   prev_a[2], prev_b[2];
    int   hist[0:2047];

    logic [7:0] ao[2], bo[2];
    logic       en[2], ini[2], lst[2];

    matmul_sequencer_if #(.M(2), .N(2), .MAXK(8)) bus_s ();
    matmul_sequencer_if #(.M(7), .N(9), .MAXK(8)) bus_d ();

    matmul_sequencer #(.M(2), .N(2), .MAXK(8)) u_small (
        .clk   (clk),
        .reset (rst_s),
        .bus   (bus_s)
    );

    matmul_sequencer #(.M(7), .N(9), .MAXK(8)) u_def (
        .clk   (clk),
        .reset (rst_d),
        .bus   (bus_d)
    );

    always #5 clk = ~clk;

    always_comb begin
        ao[0]  = 8'(bus_s.A_read_addr);
        bo[0]  = 8'(bus_s.B_read_addr);
        en[0]  = bus_s.mac_en;
        ini[0] = bus_s.mac_init;
        lst[0] = bus_s.mac_last;
        ao[1]  = 8'(bus_d.A_read_addr);
        bo[1]  = 8'(bus_d.B_read_addr);
        en[1]  = bus_d.mac_en;
        ini[1] = bus_d.mac_init;
        lst[1] = bus_d.mac_last;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Expected products of C = A*B for an m_dim x n_dim result with shared dimension k.
    task automatic push_model(input int which, input int m_dim, input int n_dim, input int k);
        exp_t e;
        for (int m = 0; m < m_dim; m++) begin
            for (int n = 0; n < n_dim; n++) begin
                for (int kk = 0; kk < k; kk++) begin
                    e.a    = m * k + kk;
                    e.b    = kk * n_dim + n;
                    e.init = (kk == 0) ? 1 : 0;
                    e.last = (kk == k - 1) ? 1 : 0;
                    if (which == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
        end
    endtask

    // Compare process: read data (and mac_en) in cycle t belongs to the address of cycle t-1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (en[i]) begin
                    exp_t e;
                    int   have;
                    have = 0;
                    if (i == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        have = 1;
                    end else if (i == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        have = 1;
                    end
                    chk($sformatf("dut%0d_mac_en_expected", i), have, 1);
                    if (have == 1) begin
                        chk($sformatf("dut%0d_a_addr", i), prev_a[i], e.a);
                        chk($sformatf("dut%0d_b_addr", i), prev_b[i], e.b);
                        chk($sformatf("dut%0d_mac_init", i), int'(ini[i]), e.init);
                        chk($sformatf("dut%0d_mac_last", i), int'(lst[i]), e.last);
                    end
                    if (i == 0) begin
                        log_a0.push_back(prev_a[0]);
                        log_b0.push_back(prev_b[0]);
                        log_i0.push_back(int'(ini[0]));
                        log_l0.push_back(int'(lst[0]));
                    end else begin
                        en_cnt1++;
                        last_a1 = prev_a[1];
                        last_b1 = prev_b[1];
                    end
                end else begin
                    chk($sformatf("dut%0d_strobe_without_en", i), int'(ini[i] | lst[i]), 0);
                end
                prev_a[i] = int'(ao[i]);
                prev_b[i] = int'(bo[i]);
            end
        end
    end

    // Runs the 2x2 instance; out_ready is low on cycles [st_from, st_to) and on cycle glitch.
    // lat = cycles from matrices_loaded until compute_finished is seen (-1 on timeout).
    task automatic run_small(input int k, input int st_from, input int st_to, input int glitch,
                             output int lat);
        push_model(0, 2, 2, k);
        log_a0.delete();
        log_b0.delete();
        log_i0.delete();
        log_l0.delete();
        bus_s.K = 4'(k);
        bus_s.matrices_loaded = 1'b1;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #3;
            hist[c] = int'(en[0]);
            bus_s.out_ready = !((c >= st_from && c < st_to) || c == glitch);
            if (bus_s.compute_finished) begin
                lat = c;
                break;
            end
        end
        bus_s.out_ready = 1'b1;
        chk("small_model_drained", q0.size(), 0);
    endtask

    task automatic run_def(input int k, output int lat);
        push_model(1, 7, 9, k);
        en_cnt1 = 0;
        last_a1 = -1;
        last_b1 = -1;
        bus_d.K = 4'(k);
        bus_d.matrices_loaded = 1'b1;
        lat = -1;
        for (int c = 1; c <= 1500; c++) begin
            @(posedge clk);
            #3;
            if (bus_d.compute_finished) begin
                lat = c;
                break;
            end
        end
        chk("def_model_drained", q1.size(), 0);
    endtask

    task automatic drop_small();
        bus_s.matrices_loaded = 1'b0;
        @(posedge clk);
        #3;
        chk("small_cf_low_after_drop", int'(bus_s.compute_finished), 0);
    endtask

    initial begin
        int lat, zeros, first_zero;
        int lit_a[8], lit_b[8], lit_i[8], lit_l[8];
        lit_a = '{0, 1, 0, 1, 2, 3, 2, 3};
        lit_b = '{0, 2, 1, 3, 0, 2, 1, 3};
        lit_i = '{1, 0, 1, 0, 1, 0, 1, 0};
        lit_l = '{0, 1, 0, 1, 0, 1, 0, 1};
        total = 0;
        bad = 0;
        en_cnt1 = 0;
        rst_s = 1'b1;
        rst_d = 1'b1;
        bus_s.matrices_loaded = 1'b0;
        bus_s.K = '0;
        bus_s.out_ready = 1'b1;
        bus_d.matrices_loaded = 1'b0;
        bus_d.K = '0;
        bus_d.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_small_a", int'(ao[0]), 0);
        chk("rst_small_b", int'(bo[0]), 0);
        chk("rst_small_mac_en", int'(en[0]), 0);
        chk("rst_small_busy", int'(bus_s.busy), 0);
        chk("rst_small_cf", int'(bus_s.compute_finished), 0);
        chk("rst_def_a", int'(ao[1]), 0);
        chk("rst_def_busy", int'(bus_d.busy), 0);
        rst_s = 1'b0;
        rst_d = 1'b0;
        @(posedge clk);
        #3;

        // 2x2x2: literal issue order and handshake latency.
        run_small(2, 0, 0, 0, lat);
        chk("k2_latency", lat, 10);
        chk("k2_mac_count", log_a0.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("k2_lit_a%0d", i), (i < log_a0.size()) ? log_a0[i] : -1, lit_a[i]);
            chk($sformatf("k2_lit_b%0d", i), (i < log_b0.size()) ? log_b0[i] : -1, lit_b[i]);
            chk($sformatf("k2_lit_init%0d", i), (i < log_i0.size()) ? log_i0[i] : -1, lit_i[i]);
            chk($sformatf("k2_lit_last%0d", i), (i < log_l0.size()) ? log_l0[i] : -1, lit_l[i]);
        end
        chk("k2_busy_in_done", int'(bus_s.busy), 0);
        // matrices_loaded held through DONE: no restart.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #3;
            chk("hold_cf", int'(bus_s.compute_finished), 1);
            chk("hold_busy", int'(bus_s.busy), 0);
        end
        drop_small();

        // K=0: straight to DONE, no products.
        run_small(0, 0, 0, 0, lat);
        chk("k0_latency", lat, 2);
        chk("k0_mac_count", log_a0.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #3;
            chk("k0_cf_held", int'(bus_s.compute_finished), 1);
        end
        drop_small();

        // Stall of 5 cycles at the start of element 2, plus a mid-element out_ready glitch.
        run_small(3, 4, 9, 10, lat);
        chk("stall_latency", lat, 19);
        chk("stall_mac_count", log_a0.size(), 12);
        zeros = 0;
        first_zero = -1;
        for (int c = 2; c < lat && c < 2048; c++) begin
            if (hist[c] == 0) begin
                zeros++;
                if (first_zero < 0) first_zero = c;
            end
        end
        chk("stall_gap_len", zeros, 5);
        chk("stall_gap_start", first_zero, 5);
        drop_small();

        // Default 7x9x8.
        run_def(8, lat);
        chk("def_latency", lat, 506);
        chk("def_mac_count", en_cnt1, 504);
        chk("def_last_a", last_a1, 55);
        chk("def_last_b", last_b1, 71);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        chk("def_cycle_count", int'(bus_d.cycle_count), 505);
`endif
        bus_d.matrices_loaded = 1'b0;
        @(posedge clk);
        #3;
        chk("def_cf_low_after_drop", int'(bus_d.compute_finished), 0);

        // Reset in the middle of RUN, then a fresh run must start from address 0.
        push_model(1, 7, 9, 8);
        bus_d.K = 4'd8;
        bus_d.matrices_loaded = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        chk("midrun_busy_before_reset", int'(bus_d.busy), 1);
        rst_d = 1'b1;
        bus_d.matrices_loaded = 1'b0;
        q1.delete();
        @(posedge clk);
        #3;
        chk("midrun_rst_a", int'(ao[1]), 0);
        chk("midrun_rst_b", int'(bo[1]), 0);
        chk("midrun_rst_mac_en", int'(en[1]), 0);
        chk("midrun_rst_strobes", int'(ini[1] | lst[1]), 0);
        chk("midrun_rst_busy", int'(bus_d.busy), 0);
        chk("midrun_rst_cf", int'(bus_d.compute_finished), 0);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        chk("midrun_rst_cycle_count", int'(bus_d.cycle_count), 0);
`endif
        rst_d = 1'b0;
        @(posedge clk);
        #3;
        run_def(3, lat);
        chk("post_rst_latency", lat, 191);
        chk("post_rst_mac_count", en_cnt1, 189);
        chk("post_rst_last_a", last_a1, 20);
        chk("post_rst_last_b", last_b1, 26);
`ifdef MATMUL_SEQ_CYCLE_COUNT_EN
        chk("post_rst_cycle_count", int'(bus_d.cycle_count), 190);
`endif
        bus_d.matrices_loaded = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that sequences the matrix-multiply compute phase once both input matrices are resident in the input memories. It walks every output element C[m][n] in row-major order and issues one A/B read-address pair per cycle. It generates MAC control strobes aligned with the registered memory read data, and closes the load/compute handshake with a four-phase `matrices_loaded` / `compute_finished` exchange. It sits between the input memory block and the MAC/output stage.

## Interface
- `M`, default 7: rows of A and C.
- `N`, default 9: columns of B and C.
- `MAXK`, default 8: maximum shared dimension K.
- Derived widths:
  - `K_BITS` = $clog2(MAXK+1)
  - `A_ADDR_BITS` = $clog2(M*MAXK)
  - `B_ADDR_BITS` = $clog2(MAXK*N)
- Clocking (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `matrices_loaded`  in  1  level; high while A and B are valid and K is stable.
- `K`  in  K_BITS  shared dimension; sampled only on the IDLE→RUN transition.
- `out_ready`  in  1  output stage can accept one more C element.
- `A_read_addr`  out  A_ADDR_BITS  A address, row-major: m*K+k.
- `B_read_addr`  out  B_ADDR_BITS  B address, row-major: k*N+n.
- `mac_en`  out  1  A/B read data valid this cycle.
- `mac_init`  out  1  with `mac_en`: first product of an element; load instead of accumulate.
- `mac_last`  out  1  with `mac_en`: final product of an element.
- `busy`  out  1  high in RUN and DRAIN.
- `compute_finished`  out  1  level; high in DONE.

## Operation
- Reset: state=IDLE; all counters and address registers are 0. Every output is 0 from the cycle after `reset` is sampled high. This holds equally for a reset asserted mid-RUN.
- States:
  - **IDLE**: when `matrices_loaded`=1, latch K into k_max, clear the m/n/k counters, and go to RUN.
    - If the latched K=0: go directly to DONE. No `mac_en` is ever produced.
  - **RUN**: each cycle, issue one read, unless stalled. After issuing:
    - k advances by 1. At k=k_max-1 it wraps to 0 and n advances.
    - At n=N-1, n wraps to 0 and m advances.
    - Issuing at (m,n,k) = (M-1,N-1,k_max-1) moves to DRAIN.
  - **DRAIN**: one cycle, letting the final read return; then go to DONE.
  - **DONE**: hold `compute_finished`=1 until `matrices_loaded`=0, then go to IDLE. There is no restart without this deassertion.
- Stall: `out_ready` is examined only when k=0 (start of an element).
  - If it is 0, nothing is issued and no `mac_en` follows.
  - Once an element has started, `out_ready` is ignored.
- Address arithmetic uses no multipliers:
  - a_row_base += k_max when m advances.
  - A_read_addr = a_row_base + k.
  - B_read_addr starts at n and adds N per k step; it reloads to the next n on wrap.
- Dropping `matrices_loaded` during RUN or DRAIN is a protocol violation. The block ignores it and completes normally.

## Timing
- An address issued in cycle t is returned by the memory in cycle t+1.
- `mac_en`, `mac_init` and `mac_last` are registered so that they are high in cycle t+1.
- IDLE→RUN costs 1 cycle; the first address is presented in the first RUN cycle.
- Without stalls: M*N*K issue cycles + 1 DRAIN cycle, then `compute_finished` rises.
- `busy` falls in the same cycle that `compute_finished` rises.

## Configuration
- `MATMUL_SEQ_CYCLE_COUNT_EN` defined:
  - Adds output port `cycle_count` (32 bits).
  - Clears to 0 on the IDLE→RUN transition.
  - Increments every cycle in RUN and DRAIN, stalls included.
  - Holds its value through DONE and IDLE; reset clears it to 0.
- Undefined: neither the port nor the counter exists; all other behaviour is identical.

## Structure
- `matmul_pkg`: the state enum (IDLE, RUN, DRAIN, DONE) and the width localparams/functions for K_BITS, A_ADDR_BITS and B_ADDR_BITS, shared with the input memory and MAC blocks.
- One sub-module, `wrap_counter`: enable, runtime max, count output, and a wrap pulse. It is instantiated three times and chained for k, n and m.

## Test plan
- M=2, N=2, K=2, `out_ready`=1:
  - (A,B) issue sequence = (0,0), (1,2), (0,1), (1,3), (2,0), (3,2), (2,1), (3,3).
  - `mac_init` on the 1st, 3rd, 5th and 7th `mac_en`; `mac_last` on the 2nd, 4th, 6th and 8th.
  - `compute_finished` rises 10 cycles after `matrices_loaded`.
- Defaults M=7, N=9, K=8: exactly 504 `mac_en` pulses; last addresses are A=55, B=71; `cycle_count`=505 when the macro is defined.
- K=0: no `mac_en`; `compute_finished` high 2 cycles after `matrices_loaded`; it stays high until `matrices_loaded`=0, then IDLE.
- Stall: hold `out_ready`=0 for 5 cycles at the start of the second element → a 5-cycle gap in `mac_en`, no duplicated or skipped addresses. Toggling `out_ready` mid-element has no effect.
- `reset` asserted mid-RUN (cycle 20 of the default config) → all outputs 0 the next cycle. After release, a fresh `matrices_loaded` runs a complete, correct sequence from address 0.
- Keep `matrices_loaded` high through DONE for 10 cycles → `compute_finished` stays high and no new RUN starts until deassertion.
